scv_hmi_matrix: RTL
===================

# scv_hmi_matrix

Keyboard/controller matrix responder for the Super Cassette Vision core. Takes the host-side `hmi_t` button state, debounces every bit, and returns active-low sense lines on CPU port B for the active-low scan column the CPU drives on port A. It also turns PAUSE presses into a latched interrupt request with an acknowledge handshake. It sits between the host input wrapper and the CPU port logic.

## Interface
- `TICK_DIV`, default 4096: clock cycles per debounce sample tick; ≥2.
- `CLK`  in  1  core clock.
- `RESB`  in  1  asynchronous active-low reset.
- `CE`  in  1  clock enable; all state (prescaler, debounce, PB, IRQ) advances only when high.
- `HMI`  in  `$bits(hmi_t)` (25)  raw button state, 1 = pressed; may change on any cycle.
- `PA`  in  8  scan columns from CPU, active low.
- `PB`  out  8  sense rows to CPU, active low, registered.
- `PAUSE_IRQ`  out  1  level interrupt request.
- `IRQ_ACK`  in  1  single-cycle acknowledge; clears `PAUSE_IRQ`.

## Operation
- Prescaler counts `0..TICK_DIV-1` on CE cycles. `tick` asserts on the CE cycle where the count wraps to 0.
- Debounce, per bit of `HMI`:
  - On `tick`, shift the raw bit into a 2-bit history.
  - The debounced bit takes the raw value when raw and both history bits agree; otherwise it holds.
  - A change therefore needs 3 consecutive agreeing ticks.
- Matrix map, column index k ↔ PA[k], rows PB[3:0]:
  - col0: c1.l, c1.u, c2.l, c2.u
  - col1: c1.d, c1.r, c2.d, c2.r
  - col2: c1.t1, c1.t2, c2.t1, c2.t2
  - col3: num[0..3]
  - col4: num[4..7]
  - col5: num[8], num[9], cl, en
  - col6, col7: no keys.
- Row n is low when any column k with PA[k]=0 holds a pressed debounced key at row n (wired-AND). This covers multiple simultaneous columns.
- PB[7:4] are always 1. PA = 8'hFF gives PB = 8'hFF.
- Pause:
  - A debounced `pause` 0→1 edge sets `PAUSE_IRQ`.
  - `IRQ_ACK` clears it.
  - If an edge and an ack land in the same CE cycle, set wins.
  - Holding pause produces no further edges. Releasing and pressing again produces a new edge.
- Reset values:
  - All history and debounced bits 0 (released).
  - Prescaler 0; `PB` = 8'hFF; `PAUSE_IRQ` = 0.
- A reset mid-debounce discards partial history. A pause held through reset does not raise an IRQ until it is released and pressed again.

## Timing
- `PB` updates on the CE cycle after `PA` or debounced state changes: 1 CE-cycle latency, no combinational PA→PB path.
- Press-to-sense latency: between 2·TICK_DIV+1 and 3·TICK_DIV+1 CE cycles, depending on tick phase. Release behaves the same way.
- `PAUSE_IRQ` rises on the CE cycle after the debounced pause edge and falls on the CE cycle after `IRQ_ACK`.
- When CE is low, inputs are ignored and all outputs hold.

## Structure
- Add to the shared `scv_pkg`:
  - `localparam int HMI_BITS = $bits(hmi_t)`
  - a typedef `hmi_matrix_t` (8 columns × 4 rows of bit).
- The debounce is a natural sub-module: `scv_debounce #(W)`. It takes `tick` and a raw W-bit vector and returns the debounced vector. It is instantiated once with W = HMI_BITS.
- The matrix map is combinational inside the top block: `hmi_t` → `hmi_matrix_t` → PB.

## Test plan
- Reset with c1.u pressed and PA = 8'hFE → PB = 8'hFF until 3 ticks after reset release; then PB = 8'hFD one CE cycle later.
- Debounced num[5] held, PA stepped FF→EF→FF → PB goes FF→FD→FF, each change one CE cycle after PA.
- c1.l and c2.t2 held, PA = 8'hFA (col0 and col2) → PB = 8'hF6; PA = 8'h3F → PB = 8'hFF.
- c1.t1 glitch: pressed for 1 tick then released → PB stays FF with PA = FB. Held for 3 ticks → PB = FE.
- Pause pressed → PAUSE_IRQ = 1; held 10 ticks plus ack → IRQ stays 0. Released and re-pressed with ack on the same cycle as the new edge → IRQ stays 1.
- CE held low for 10000 cycles while c2.r is pressed → PB and IRQ frozen and prescaler halted; on resuming CE, debounce completes after the expected tick count.

Source files
------------

// File: rtl/scv_pkg.sv
// rtl/scv_pkg.sv - shared Super Cassette Vision types: host button state and key matrix
//
// Purpose: types shared by the SCV core blocks.
//   pad_t        - one controller: directions plus two triggers, 1 = pressed
//   hmi_t        - full host-side button state (25 bits)
//   hmi_matrix_t - 8 scan columns x 4 sense rows, 1 = key pressed
//   hmi_to_matrix- places each hmi_t key at its column/row position

package scv_pkg;

    typedef struct packed {
        logic l;
        logic u;
        logic d;
        logic r;
        logic t1;
        logic t2;
    } pad_t;

    typedef struct packed {
        pad_t       c1;
        pad_t       c2;
        logic [9:0] num;
        logic       cl;
        logic       en;
        logic       pause;
    } hmi_t;

    localparam int HMI_BITS = $bits(hmi_t);

    // Indexed [column][row]; row 0 is the least significant PB bit.
    typedef logic [7:0][3:0] hmi_matrix_t;

    // Pause is not part of the scanned matrix; it is handled as an interrupt.
    function automatic hmi_matrix_t hmi_to_matrix(input hmi_t h);
        hmi_matrix_t m;
        m    = '0;
        m[0] = {h.c2.u,  h.c2.l,  h.c1.u,  h.c1.l};
        m[1] = {h.c2.r,  h.c2.d,  h.c1.r,  h.c1.d};
        m[2] = {h.c2.t2, h.c2.t1, h.c1.t2, h.c1.t1};
        m[3] = h.num[3:0];
        m[4] = h.num[7:4];
        m[5] = {h.en, h.cl, h.num[9], h.num[8]};
        return m;
    endfunction

endpackage

// File: rtl/scv_debounce.sv
// rtl/scv_debounce.sv - per-bit three-sample debounce filter
//
// Purpose: each bit keeps a 2-sample history taken on i_tick; the output bit
// follows the raw bit only when the raw value and both history samples agree,
// so a change needs three consecutive agreeing ticks.
// Ports:
//   i_clk    core clock
//   i_rst_n  asynchronous active-low reset, clears history and outputs
//   i_tick   sample strobe (already qualified by the clock enable)
//   i_raw    raw W-bit input
//   o_deb    debounced W-bit output

module scv_debounce #(
    parameter int W = 1
) (
    input  logic         i_clk,
    input  logic         i_rst_n,
    input  logic         i_tick,
    input  logic [W-1:0] i_raw,
    output logic [W-1:0] o_deb
);

    logic [W-1:0] r_h0;     // most recent sample
    logic [W-1:0] r_h1;     // sample before that
    logic [W-1:0] r_deb;
    logic [W-1:0] w_agree;
    logic [W-1:0] w_next;

    assign w_agree = ~(i_raw ^ r_h0) & ~(i_raw ^ r_h1);
    assign w_next  = (w_agree & i_raw) | (~w_agree & r_deb);

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_h0  <= '0;
            r_h1  <= '0;
            r_deb <= '0;
        end else if (i_tick) begin
            r_h1  <= r_h0;
            r_h0  <= i_raw;
            r_deb <= w_next;
        end
    end

    assign o_deb = r_deb;

endmodule

// File: rtl/scv_hmi_matrix.sv
// rtl/scv_hmi_matrix.sv - SCV keyboard/controller matrix responder with pause interrupt
//
// Purpose: debounces host button state, answers CPU column scans with
// active-low sense rows, and latches PAUSE presses as an interrupt request.
// Ports:
//   CLK        core clock
//   RESB       asynchronous active-low reset
//   CE         clock enable; all state advances only when high
//   HMI        raw button state, 1 = pressed
//   PA         scan columns from CPU, active low
//   PB         sense rows to CPU, active low, registered; PB[7:4] always 1
//   PAUSE_IRQ  level interrupt request raised by a debounced pause press
//   IRQ_ACK    single-cycle acknowledge, clears PAUSE_IRQ

module scv_hmi_matrix
    import scv_pkg::*;
#(
    parameter int TICK_DIV = 4096
) (
    input  logic       CLK,
    input  logic       RESB,
    input  logic       CE,
    input  hmi_t       HMI,
    input  logic [7:0] PA,
    output logic [7:0] PB,
    output logic       PAUSE_IRQ,
    input  logic       IRQ_ACK
);

    localparam int              CW   = $clog2(TICK_DIV);
    localparam logic [CW-1:0]   LAST = CW'(TICK_DIV - 1);

    logic [CW-1:0]         r_cnt;
    logic                  w_tick;
    logic [HMI_BITS-1:0]   w_deb;
    hmi_t                  w_deb_s;
    hmi_matrix_t           w_mat;
    logic [3:0]            w_rows;
    logic [7:0]            r_pb;
    logic                  r_pause_prev;
    logic                  r_armed;
    logic                  r_irq;
    logic                  w_pause_rise;

    // Sample-tick prescaler.
    assign w_tick = CE && (r_cnt == LAST);

    always_ff @(posedge CLK or negedge RESB) begin
        if (!RESB) begin
            r_cnt <= '0;
        end else if (CE) begin
            r_cnt <= (r_cnt == LAST) ? '0 : r_cnt + 1'b1;
        end
    end

    scv_debounce #(
        .W (HMI_BITS)
    ) u_debounce (
        .i_clk   (CLK),
        .i_rst_n (RESB),
        .i_tick  (w_tick),
        .i_raw   (HMI),
        .o_deb   (w_deb)
    );

    assign w_deb_s = w_deb;
    assign w_mat   = hmi_to_matrix(w_deb_s);

    // Wired-AND of every selected column: a row is pulled low by any
    // low PA column that holds a pressed key on that row.
    always_comb begin
        w_rows = '0;
        for (int k = 0; k < 8; k++) begin
            if (!PA[k]) begin
                w_rows = w_rows | w_mat[k];
            end
        end
    end

    always_ff @(posedge CLK or negedge RESB) begin
        if (!RESB) begin
            r_pb <= 8'hFF;
        end else if (CE) begin
            r_pb <= {4'hF, ~w_rows};
        end
    end

    // r_armed blocks the edge produced when a pause held through reset
    // finishes debouncing; it arms once a tick samples pause released.
    assign w_pause_rise = w_deb_s.pause & ~r_pause_prev & r_armed;

    always_ff @(posedge CLK or negedge RESB) begin
        if (!RESB) begin
            r_pause_prev <= 1'b0;
            r_armed      <= 1'b0;
            r_irq        <= 1'b0;
        end else if (CE) begin
            r_pause_prev <= w_deb_s.pause;
            if (w_tick && !HMI.pause) begin
                r_armed <= 1'b1;
            end
            // A new press outranks an acknowledge in the same cycle.
            if (w_pause_rise) begin
                r_irq <= 1'b1;
            end else if (IRQ_ACK) begin
                r_irq <= 1'b0;
            end
        end
    end

    assign PB        = r_pb;
    assign PAUSE_IRQ = r_irq;

endmodule
